// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - OP_* : 4-bit opcode encodings presented on seq_alu.sel
//   - state_t : control FSM states (IDLE accepts, BUSY iterates, DONE presents)
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOTA = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SLA  = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_RSVD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative unsigned multiplier / restoring divider, one bit per cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : load operands and begin WIDTH iterations
//   op_div       : 0 = multiply (a*b), 1 = divide (a/b); sampled with start
//   a, b         : operands, sampled with start
//   done         : high for the cycle after the last iteration; result is valid then
//   result       : low WIDTH bits of the product, or the quotient
//   hi_nonzero   : high half of the 2*WIDTH product is non-zero (multiply only)
//   div0         : combinational, b == 0 (caller uses it to bypass the iteration)
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nonzero,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH) + 1;

    // acc_q holds {high half, low half}:
    //   multiply: {partial product, remaining multiplier bits}
    //   divide  : {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
    logic               div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        // Remainder stays below the divisor, so it always fits in WIDTH bits.
        rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

        acc_d  = acc_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        run_d  = run_q;

        if (start) begin
            acc_d  = {{WIDTH{1'b0}}, (op_div ? a : b)};
            opnd_d = op_div ? b : a;
            div_d  = op_div;
            cnt_d  = CW'(WIDTH);
            run_d  = 1'b1;
        end else if (run_q && (cnt_q != '0)) begin
            if (div_q) begin
                acc_d = {rem_next, acc_q[WIDTH-2:0], div_ge};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
        end else if (run_q) begin
            run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign done       = run_q && (cnt_q == '0);
    assign result     = acc_q[WIDTH-1:0];
    assign hi_nonzero = |acc_q[2*WIDTH-1:WIDTH];
    assign div0       = ~|b;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes, one operation in flight.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_valid, in_ready           : request handshake (sel, A, B, Cin sampled on accept)
//   sel, A, B, Cin               : opcode, operands, carry-in (ADD only)
//   out_valid, out_ready         : result handshake
//   Y, Cout, Negative, Zero, Overflow : registered result and flags
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A request is taken only when in_ready is high; a result stays on Y and
// the flags, unchanged, while out_valid is high and out_ready is low. in_ready
// is high in IDLE and, in DONE, follows out_ready so a new op can be accepted
// in the same cycle the previous result is consumed.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             Negative,
    output logic             Zero,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   shl_full;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] sra_res;
    logic             slt_bit;

    logic [WIDTH-1:0] sc_y;
    logic             sc_cout;
    logic             sc_ovf;
    logic             sc_neg_en;

    always_comb begin
        sh_amt   = B[SHW-1:0];
        add_full = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
        sub_res  = A - B;
        // Shifting one bit wider leaves the last bit shifted out in bit WIDTH
        // (and 0 there when the amount is 0).
        shl_full = {1'b0, A} << sh_amt;
        srl_res  = A >> sh_amt;
        sra_res  = $signed(A) >>> sh_amt;
        slt_bit  = ($signed(A) < $signed(B));
    end

    always_comb begin
        sc_y      = '0;
        sc_cout   = 1'b0;
        sc_ovf    = 1'b0;
        sc_neg_en = 1'b1;
        case (sel)
            OP_AND:  sc_y = A & B;
            OP_OR:   sc_y = A | B;
            OP_NOTA: sc_y = ~A;
            OP_NOR:  sc_y = ~(A | B);
            OP_XOR:  sc_y = A ^ B;
            OP_NAND: sc_y = ~(A & B);
            OP_ADD: begin
                sc_y    = add_full[WIDTH-1:0];
                sc_cout = add_full[WIDTH];
                sc_ovf  = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
            end
            OP_SUB: begin
                sc_y    = sub_res;
                sc_cout = (A >= B);
                sc_ovf  = (A[MSB] != B[MSB]) && (sub_res[MSB] != A[MSB]);
            end
            OP_SLT: begin
                sc_y      = {{(WIDTH-1){1'b0}}, slt_bit};
                sc_neg_en = 1'b0;
            end
            OP_MUL: sc_neg_en = 1'b0;       // result comes from the iterator
            OP_SLL, OP_SLA: begin
                sc_y    = shl_full[WIDTH-1:0];
                sc_cout = shl_full[WIDTH];
                sc_ovf  = shl_full[MSB] ^ A[MSB];
            end
            OP_SRL:  sc_y = srl_res;
            OP_SRA:  sc_y = sra_res;
            OP_DIVU: begin
                // Only reaches the output directly when dividing by zero.
                sc_y      = '1;
                sc_ovf    = 1'b1;
                sc_neg_en = 1'b0;
            end
            default: begin                  // OP_RSVD
                sc_y      = '0;
                sc_ovf    = 1'b1;
                sc_neg_en = 1'b0;
            end
        endcase
    end

    // ---------------- iterative multiply / divide ----------------
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             md_hi_nz;
    logic             md_div0;
    logic             sel_is_div;

    assign sel_is_div = (sel == OP_DIVU);

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (md_start),
        .op_div     (sel_is_div),
        .a          (A),
        .b          (B),
        .done       (md_done),
        .result     (md_result),
        .hi_nonzero (md_hi_nz),
        .div0       (md_div0)
    );

    // ---------------- control FSM and output registers ----------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             is_mul_q, is_mul_d;

    logic             accept;
    logic             needs_iter;

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign needs_iter = (sel == OP_MUL) || (sel_is_div && !md_div0);

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        cout_d      = cout_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        is_mul_d    = is_mul_q;
        md_start    = 1'b0;

        case (state_q)
            ST_BUSY: begin
                if (md_done) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    y_d         = md_result;
                    zero_d      = ~|md_result;
                    neg_d       = 1'b0;
                    cout_d      = is_mul_q && md_hi_nz;
                    ovf_d       = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Accept overrides the above; it can only occur in IDLE or DONE.
        if (accept) begin
            if (needs_iter) begin
                state_d     = ST_BUSY;
                out_valid_d = 1'b0;
                is_mul_d    = (sel == OP_MUL);
                md_start    = 1'b1;
            end else begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                y_d         = sc_y;
                zero_d      = ~|sc_y;
                neg_d       = sc_neg_en && sc_y[MSB];
                cout_d      = sc_cout;
                ovf_d       = sc_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            cout_q      <= 1'b0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            is_mul_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            cout_q      <= cout_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            is_mul_q    <= is_mul_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign Cout      = cout_q;
    assign Negative  = neg_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the combinational 4-bit-select ALU. Executes full-width bitwise, add/sub, compare, variable shifts, and multi-cycle unsigned multiply/divide behind valid/ready handshakes. Sits between the operand-fetch stage and the writeback/flag register of the datapath. One operation is in flight at a time.

## Interface

- `WIDTH`, 32: operand/result width, ≥4, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width, derived, not overridden.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `sel` in 4: opcode.
- `A`, `B` in WIDTH: operands.
- `Cin` in 1: carry-in, used by ADD only.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `Y` out WIDTH: result.
- `Cout`, `Negative`, `Zero`, `Overflow` out 1 each: flags.

## Operation

- Opcodes:
  - 0000 AND, 0001 OR, 0010 NOT A, 0011 NOR, 0100 XOR, 0101 NAND: bitwise, full width.
  - 0110 ADD: A+B+Cin.
  - 0111 SUB: A−B.
  - 1000 SLT: Y = {0…, signed(A)<signed(B)}.
  - 1001 MUL: unsigned, low WIDTH bits.
  - 1010 SLL and 1011 SLA: identical, A << B[SHW-1:0].
  - 1100 SRL: logical right shift.
  - 1101 SRA: arithmetic right shift.
  - 1110 DIVU: Y = A/B.
  - 1111 reserved: Y = 0, Overflow = 1.
- Flags:
  - Zero = (Y==0) for every op.
  - Negative = Y[WIDTH-1], except forced 0 for SLT, MUL, DIVU and reserved.
  - ADD: Cout = carry out of WIDTH; Overflow = signed overflow (operands same sign, result differs).
  - SUB: Cout = no-borrow (A ≥ B unsigned); Overflow = operands differ in sign and result sign ≠ A sign.
  - Shifts left: Cout = last bit shifted out (0 if amount 0); Overflow = Y[MSB] ^ A[MSB].
  - MUL: Cout = |high half of the 2·WIDTH product.
  - DIVU by zero: Y = all ones, Overflow = 1.
  - All other Cout/Overflow cases = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On accept, MUL/DIVU → BUSY with operands latched and iteration counter = WIDTH; all other ops → DONE.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIVU) step per cycle; counter decrements; at counter==1 step, → DONE. DIVU with B==0 skips BUSY and goes straight to DONE.
  - DONE: out_valid=1. Y and flags held stable until handshake. in_ready = out_ready, so back-to-back ops are allowed. On out_ready: if in_valid, accept the new op (→ DONE or BUSY); else → IDLE.
- Inputs are sampled only at accept; A/B/sel changes afterwards have no effect.

## Timing

- Reset (async assert, synchronous deassert by the upstream reset synchroniser):
  - state = IDLE.
  - Y = 0, all flags = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after deassert.
- Single-cycle ops: accepted at edge N, out_valid high after edge N (latency 1). Sustained throughput 1 op/cycle when out_ready=1.
- MUL/DIVU: out_valid high WIDTH+1 cycles after accept. in_ready=0 throughout BUSY.
- out_ready low in DONE: outputs frozen indefinitely; in_ready=0.
- Reset mid-BUSY or mid-DONE: operation discarded, no output produced.
- out_ready and in_valid may be high in IDLE/BUSY; out_ready is ignored there.

## Structure

- Package `alu_pkg`:
  - opcode localparams (OP_AND … OP_RSVD).
  - FSM state enum.
- Sub-module `iter_muldiv`:
  - parametrised by WIDTH.
  - start/op/A/B in; done, result, hi_nonzero, div0 out.
  - owns the counter and the partial-product / remainder registers.
- Top level: opcode decode, single-cycle datapath, flag logic, FSM, output registers.

## Test plan

- WIDTH=32, ADD A=0x7FFFFFFF B=1 Cin=0 → Y=0x80000000, Overflow=1, Negative=1, Cout=0, out_valid one cycle after accept.
- SUB A=5 B=7 → Y=0xFFFFFFFE, Cout=0, Negative=1. SLT on same operands → Y=1.
- MUL A=0x10000 B=0x10000 → Y=0, Zero=1, Cout=1, out_valid exactly 33 cycles after accept; in_ready=0 during BUSY.
- DIVU A=100 B=7 → Y=14. DIVU B=0 → Y=0xFFFFFFFF, Overflow=1, out_valid next cycle.
- Back-to-back XOR, SRA(A=0x80000000, B=4 → 0xF8000000), SLL(A=0x80000001, B=1 → Y=2, Cout=1) with out_ready=1 → three results on consecutive cycles. Repeat with out_ready held low 5 cycles → first result stable, in_ready=0.
- Assert rst_n low mid-MUL (cycle 10) → out_valid=0, Y=0, flags 0 immediately. After release, an ADD completes normally.
